// File: rtl/csa_multi_operand_adder.sv
// Multi-operand adder: 3:2 compressor tree into a registered carry-save pair, then a CPA stage.
// Optional macro CSA_REDUNDANT_OUT_EN exposes the carry-save pair (out_s/out_c) alongside out_sum.
module csa_multi_operand_adder #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum
`ifdef CSA_REDUNDANT_OUT_EN
  ,
  output logic [WIDTH-1:0]         out_s,
  output logic [WIDTH-1:0]         out_c
`endif
);

  // Each layer turns every full group of three vectors into two; leftovers pass through.
  function automatic int layer_count(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    for (int k = 0; k < 8; k++) begin
      if (m > 2) begin
        m = 2 * (m / 3) + m % 3;
        l++;
      end
    end
    return l;
  endfunction

  function automatic logic [WIDTH-1:0] csa_carry(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] cy;
    cy = (a & b) | (c & (a ^ b));
    return {cy[WIDTH-2:0], 1'b0};
  endfunction

  localparam int NUM_LAYERS = layer_count(NUM_OPS);
  localparam int SLOTS      = NUM_OPS + 2;

  generate
    if (NUM_OPS < 3 || NUM_OPS > 8 || WIDTH < 2) begin : g_bad_params
      $error("csa_multi_operand_adder: NUM_OPS must be 3..8 and WIDTH >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] ops [0:NUM_OPS-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_unpack
      assign ops[gi] = in_ops[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] carry_comb;

  always_comb begin : reduce
    logic [WIDTH-1:0] cur [0:SLOTS-1];
    logic [WIDTH-1:0] nxt [0:SLOTS-1];
    int n;
    int groups;
    cur = '{default: '0};
    nxt = '{default: '0};
    n = NUM_OPS;
    groups = 0;
    for (int i = 0; i < NUM_OPS; i++) cur[i] = ops[i];
    for (int l = 0; l < NUM_LAYERS; l++) begin
      nxt = '{default: '0};
      groups = n / 3;
      for (int g = 0; g < NUM_OPS / 3; g++) begin
        if (g < groups) begin
          nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
          nxt[2*g+1] = csa_carry(cur[3*g], cur[3*g+1], cur[3*g+2]);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < n % 3) nxt[2*groups+r] = cur[3*groups+r];
      end
      cur = nxt;
      n = 2 * groups + n % 3;
    end
    sum_comb   = cur[0];
    carry_comb = cur[1];
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_sum;
  logic [WIDTH-1:0] s1_carry;
  logic             adv1;
  logic             adv2;

  // Stall-based pipeline: a stage moves when it is empty or the one after it moves.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_carry  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef CSA_REDUNDANT_OUT_EN
      out_s     <= '0;
      out_c     <= '0;
`endif
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        s1_sum   <= sum_comb;
        s1_carry <= carry_comb;
      end
      if (adv2) begin
        out_valid <= s1_valid;
        out_sum   <= s1_sum + s1_carry;
`ifdef CSA_REDUNDANT_OUT_EN
        out_s     <= s1_sum;
        out_c     <= s1_carry;
`endif
      end
    end
  end

endmodule
